z80_alu_serial: RTL and testbench

Width-parametrised, slice-serial Z80 ALU engine executing ADD/ADC/SUB/SBC/AND/XOR/OR/CP on WIDTH-bit operands, SLICE bits per clock, LSB first, the way the real Z80 ALU works nibble-serially. It produces the result and Z80-format flags behind a valid/ready handshake. It is the execution-side counterpart of the 8-bit A,n instruction spec, generalised to 16-bit operations such as ADC/SBC HL,rr. Flag semantics match the instruction specs so formal checks can compare the two directly.

---
 rtl/z80_alu_serial.sv | 251 +++++++++++++++++++++++++
 tb/tb_z80_alu_serial.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_alu_serial.sv
// z80_alu_serial: slice-serial Z80 ALU (ADD/ADC/SUB/SBC/AND/XOR/OR/CP).
// The operands are consumed SLICE bits per clock, LSB first. The result
// and the Z80-format F register are presented behind a valid/ready pair.
module z80_alu_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [7:0]       f_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       f_out
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [2:0] ALU_FUNC_ADD = 3'd0;
  localparam logic [2:0] ALU_FUNC_ADC = 3'd1;
  localparam logic [2:0] ALU_FUNC_SUB = 3'd2;
  localparam logic [2:0] ALU_FUNC_SBC = 3'd3;
  localparam logic [2:0] ALU_FUNC_AND = 3'd4;
  localparam logic [2:0] ALU_FUNC_XOR = 3'd5;
  localparam logic [2:0] ALU_FUNC_OR  = 3'd6;
  localparam logic [2:0] ALU_FUNC_CP  = 3'd7;

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
      $error("z80_alu_serial: WIDTH must be a multiple of 4 and at least 8");
    end
    if (!((SLICE == 1) || (SLICE == 2) || (SLICE == 4))) begin : g_bad_slice
      $error("z80_alu_serial: SLICE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Z80 parity flag: 1 when the number of set bits is even.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ~(^v);
  endfunction

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;          // rotates back to the captured a_in after N slices
  logic [WIDTH-1:0] b_q, b_d;          // b_in, pre-inverted for subtract-type ops
  logic [WIDTH-1:0] r_q, r_d;          // result being shifted in from the top
  logic [WIDTH-1:0] result_q, result_d;
  logic [7:0]       f_out_q, f_out_d;
  logic             c_q, c_d;          // running carry between slices
  logic             nz_q, nz_d;        // any result bit seen set so far
  logic             hc_q, hc_d;        // carry out of bit WIDTH-5
  logic             cm_q, cm_d;        // carry into bit WIDTH-1
  logic             f5_q, f5_d;
  logic             f3_q, f3_d;

  logic             sub_in_s, cin_in_s, is_sub_s, is_cp_s;
  logic [SLICE-1:0] a_sl_s, b_sl_s, sum_sl_s, r_sl_s;
  logic             cy_s, hc_n_s, cm_n_s;
  logic [WIDTH-1:0] a_rot_s, r_next_s;
  logic             s_s, z_s, h_s, pv_s, n_s, cf_s;
  logic             unused_f_s;

  assign unused_f_s = &{1'b0, f_in[7:6], f_in[4], f_in[2:1]};

  // Slice datapath: ripple-add (or bitwise op) on the low slice of a/b.
  always_comb begin
    a_sl_s   = a_q[SLICE-1:0];
    b_sl_s   = b_q[SLICE-1:0];
    sum_sl_s = {SLICE{1'b0}};
    cy_s     = c_q;
    hc_n_s   = hc_q;
    cm_n_s   = cm_q;
    for (int i = 0; i < SLICE; i++) begin
      cm_n_s      = ((int'(k_q) * SLICE + i) == (WIDTH - 1)) ? cy_s : cm_n_s;
      sum_sl_s[i] = a_sl_s[i] ^ b_sl_s[i] ^ cy_s;
      cy_s        = (a_sl_s[i] & b_sl_s[i]) | (a_sl_s[i] & cy_s) | (b_sl_s[i] & cy_s);
      hc_n_s      = ((int'(k_q) * SLICE + i) == (WIDTH - 5)) ? cy_s : hc_n_s;
    end
    case (op_q)
      ALU_FUNC_AND: r_sl_s = a_sl_s & b_sl_s;
      ALU_FUNC_XOR: r_sl_s = a_sl_s ^ b_sl_s;
      ALU_FUNC_OR:  r_sl_s = a_sl_s | b_sl_s;
      default:      r_sl_s = sum_sl_s;
    endcase
    a_rot_s  = {a_sl_s, a_q[WIDTH-1:SLICE]};
    r_next_s = {r_sl_s, r_q[WIDTH-1:SLICE]};
  end

  // Flag formation, meaningful on the last slice of an operation.
  always_comb begin
    is_sub_s = (op_q == ALU_FUNC_SUB) || (op_q == ALU_FUNC_SBC) || (op_q == ALU_FUNC_CP);
    is_cp_s  = (op_q == ALU_FUNC_CP);
    s_s      = r_next_s[WIDTH-1];
    z_s      = ~(nz_q | (|r_sl_s));
    n_s      = is_sub_s;
    case (op_q)
      ALU_FUNC_ADD, ALU_FUNC_ADC: begin
        h_s  = hc_n_s;
        pv_s = cm_n_s ^ cy_s;
        cf_s = cy_s;
      end
      ALU_FUNC_SUB, ALU_FUNC_SBC, ALU_FUNC_CP: begin
        h_s  = ~hc_n_s;
        pv_s = cm_n_s ^ cy_s;
        cf_s = ~cy_s;
      end
      ALU_FUNC_AND: begin
        h_s  = 1'b1;
        pv_s = even_parity(r_next_s);
        cf_s = 1'b0;
      end
      ALU_FUNC_XOR, ALU_FUNC_OR: begin
        h_s  = 1'b0;
        pv_s = even_parity(r_next_s);
        cf_s = 1'b0;
      end
      default: begin
        h_s  = 1'b0;
        pv_s = 1'b0;
        cf_s = 1'b0;
      end
    endcase
  end

  // Request decode used only on the accept edge.
  always_comb begin
    sub_in_s = (op == ALU_FUNC_SUB) || (op == ALU_FUNC_SBC) || (op == ALU_FUNC_CP);
    cin_in_s = ((op == ALU_FUNC_ADC) || (op == ALU_FUNC_SBC)) ? f_in[0] : 1'b0;
  end

  // Next-state logic: IDLE accepts, RUN steps one slice, DONE waits for out_ready.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    result_d = result_q;
    f_out_d  = f_out_q;
    c_d      = c_q;
    nz_d     = nz_q;
    hc_d     = hc_q;
    cm_d     = cm_q;
    f5_d     = f5_q;
    f3_d     = f3_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          k_d     = {KW{1'b0}};
          op_d    = op;
          a_d     = a_in;
          b_d     = sub_in_s ? ~b_in : b_in;
          r_d     = {WIDTH{1'b0}};
          c_d     = sub_in_s ^ cin_in_s;
          nz_d    = 1'b0;
          hc_d    = 1'b0;
          cm_d    = 1'b0;
          f5_d    = f_in[5];
          f3_d    = f_in[3];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d  = a_rot_s;
        b_d  = {b_sl_s, b_q[WIDTH-1:SLICE]};
        r_d  = r_next_s;
        c_d  = cy_s;
        nz_d = nz_q | (|r_sl_s);
        hc_d = hc_n_s;
        cm_d = cm_n_s;
        if (k_q == K_LAST) begin
          state_d  = ST_DONE;
          k_d      = {KW{1'b0}};
          result_d = is_cp_s ? a_rot_s : r_next_s;
          f_out_d  = {s_s, z_s, f5_q, h_s, f3_q, pv_s, n_s, cf_s};
        end else begin
          k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = {KW{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      k_q      <= {KW{1'b0}};
      op_q     <= 3'd0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      f_out_q  <= 8'h00;
      c_q      <= 1'b0;
      nz_q     <= 1'b0;
      hc_q     <= 1'b0;
      cm_q     <= 1'b0;
      f5_q     <= 1'b0;
      f3_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      result_q <= result_d;
      f_out_q  <= f_out_d;
      c_q      <= c_d;
      nz_q     <= nz_d;
      hc_q     <= hc_d;
      cm_q     <= cm_d;
      f5_q     <= f5_d;
      f3_q     <= f3_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign f_out     = f_out_q;

endmodule

// File: tb/tb_z80_alu_serial.sv
// Directed bench for z80_alu_serial: three configurations
// (8-bit/4-bit slices, 8-bit/1-bit slices, 16-bit/4-bit slices).
module tb_z80_alu_serial;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_CP  = 3'd7;

  logic clk;
  logic reset_n;

  logic        iv_a, ir_a, ov_a, or_a;
  logic [2:0]  op_a;
  logic [7:0]  a_a, b_a, f_a, r_a, fo_a;

  logic        iv_b, ir_b, ov_b, or_b;
  logic [2:0]  op_b;
  logic [7:0]  a_b, b_b, f_b, r_b, fo_b;

  logic        iv_c, ir_c, ov_c, or_c;
  logic [2:0]  op_c;
  logic [15:0] a_c, b_c, r_c;
  logic [7:0]  f_c, fo_c;

  int checks;
  int failures;

  z80_alu_serial #(.WIDTH(8), .SLICE(4)) u_w8s4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv_a), .in_ready(ir_a), .op(op_a),
    .a_in(a_a), .b_in(b_a), .f_in(f_a), .out_valid(ov_a), .out_ready(or_a),
    .result(r_a), .f_out(fo_a));

  z80_alu_serial #(.WIDTH(8), .SLICE(1)) u_w8s1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv_b), .in_ready(ir_b), .op(op_b),
    .a_in(a_b), .b_in(b_b), .f_in(f_b), .out_valid(ov_b), .out_ready(or_b),
    .result(r_b), .f_out(fo_b));

  z80_alu_serial #(.WIDTH(16), .SLICE(4)) u_w16s4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv_c), .in_ready(ir_c), .op(op_c),
    .a_in(a_c), .b_in(b_c), .f_in(f_c), .out_valid(ov_c), .out_ready(or_c),
    .result(r_c), .f_out(fo_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    iv_a = 1'b0; or_a = 1'b0; op_a = 3'd0; a_a = 8'h00; b_a = 8'h00; f_a = 8'h00;
    iv_b = 1'b0; or_b = 1'b0; op_b = 3'd0; a_b = 8'h00; b_b = 8'h00; f_b = 8'h00;
    iv_c = 1'b0; or_c = 1'b0; op_c = 3'd0; a_c = 16'h0000; b_c = 16'h0000; f_c = 8'h00;
    tick;
    tick;

    // Reset state
    chk("rst_in_ready_8",   {15'd0, ir_a}, 16'd1);
    chk("rst_out_valid_8",  {15'd0, ov_a}, 16'd0);
    chk("rst_result_8",     {8'd0, r_a},   16'h0000);
    chk("rst_fout_8",       {8'd0, fo_a},  16'h0000);
    chk("rst_in_ready_16",  {15'd0, ir_c}, 16'd1);
    chk("rst_out_valid_16", {15'd0, ov_c}, 16'd0);
    chk("rst_result_16",    r_c,           16'h0000);
    chk("rst_fout_16",      {8'd0, fo_c},  16'h0000);
    reset_n = 1'b1;
    tick;

    // ADD 0x7F + 0x01 on 8-bit / 4-bit slices: two RUN cycles
    op_a = OP_ADD; a_a = 8'h7F; b_a = 8'h01; f_a = 8'h00; iv_a = 1'b1;
    tick;
    iv_a = 1'b0; a_a = 8'hAA; b_a = 8'h55; f_a = 8'hFF;
    chk("add_run_in_ready", {15'd0, ir_a}, 16'd0);
    tick;
    chk("add_run_out_valid", {15'd0, ov_a}, 16'd0);
    tick;
    chk("add_out_valid", {15'd0, ov_a}, 16'd1);
    chk("add_result",    {8'd0, r_a},   16'h0080);
    chk("add_fout",      {8'd0, fo_a},  16'h0094);

    // Backpressure: DONE held with outputs stable
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_out_valid", {15'd0, ov_a}, 16'd1);
      chk("bp_result",    {8'd0, r_a},   16'h0080);
      chk("bp_fout",      {8'd0, fo_a},  16'h0094);
      chk("bp_in_ready",  {15'd0, ir_a}, 16'd0);
    end

    // Pulse out_ready with the next request already pending
    op_a = OP_AND; a_a = 8'hF0; b_a = 8'h3C; f_a = 8'h00; iv_a = 1'b1; or_a = 1'b1;
    tick;
    or_a = 1'b0;
    chk("bp_release_in_ready",  {15'd0, ir_a}, 16'd1);
    chk("bp_release_out_valid", {15'd0, ov_a}, 16'd0);
    tick;
    chk("and_accepted", {15'd0, ir_a}, 16'd0);
    iv_a = 1'b0;
    tick;
    chk("and_run_out_valid", {15'd0, ov_a}, 16'd0);
    tick;
    chk("and_out_valid", {15'd0, ov_a}, 16'd1);
    chk("and_result",    {8'd0, r_a},   16'h0030);
    chk("and_fout",      {8'd0, fo_a},  16'h0014);

    // CP with out_ready held high; no accept while in DONE
    op_a = OP_CP; a_a = 8'h42; b_a = 8'h42; f_a = 8'h28; iv_a = 1'b1; or_a = 1'b1;
    tick;
    chk("cp_idle_in_ready",  {15'd0, ir_a}, 16'd1);
    chk("cp_idle_out_valid", {15'd0, ov_a}, 16'd0);
    tick;
    chk("cp_accepted", {15'd0, ir_a}, 16'd0);
    iv_a = 1'b0;
    tick;
    tick;
    chk("cp_out_valid", {15'd0, ov_a}, 16'd1);
    chk("cp_result",    {8'd0, r_a},   16'h0042);
    chk("cp_fout",      {8'd0, fo_a},  16'h006A);
    tick;
    chk("cp_back_idle", {15'd0, ir_a}, 16'd1);
    chk("cp_drained",   {15'd0, ov_a}, 16'd0);
    or_a = 1'b0;

    // SUB 0x00 - 0x01 on 8-bit / 1-bit slices: eight RUN cycles
    op_b = OP_SUB; a_b = 8'h00; b_b = 8'h01; f_b = 8'h00; iv_b = 1'b1;
    tick;
    iv_b = 1'b0; a_b = 8'h12; b_b = 8'h34;
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("sub_run_in_ready",  {15'd0, ir_b}, 16'd0);
      chk("sub_run_out_valid", {15'd0, ov_b}, 16'd0);
    end
    tick;
    chk("sub_out_valid", {15'd0, ov_b}, 16'd1);
    chk("sub_result",    {8'd0, r_b},   16'h00FF);
    chk("sub_fout",      {8'd0, fo_b},  16'h0093);
    or_b = 1'b1;
    tick;
    or_b = 1'b0;
    chk("sub_back_idle", {15'd0, ir_b}, 16'd1);

    // ADC 0xFFFF + 0x0000 + C on 16-bit / 4-bit slices
    op_c = OP_ADC; a_c = 16'hFFFF; b_c = 16'h0000; f_c = 8'h01; iv_c = 1'b1;
    tick;
    iv_c = 1'b0;
    tick;
    tick;
    tick;
    chk("adc_run_out_valid", {15'd0, ov_c}, 16'd0);
    tick;
    chk("adc_out_valid", {15'd0, ov_c}, 16'd1);
    chk("adc_result",    r_c,           16'h0000);
    chk("adc_fout",      {8'd0, fo_c},  16'h0051);
    or_c = 1'b1;
    tick;
    or_c = 1'b0;

    // Reset asserted in the middle of a 16-bit RUN
    op_c = OP_ADD; a_c = 16'h1234; b_c = 16'h1111; f_c = 8'h00; iv_c = 1'b1;
    tick;
    iv_c = 1'b0;
    tick;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {15'd0, ov_c}, 16'd0);
    chk("midrst_fout",      {8'd0, fo_c},  16'h0000);
    chk("midrst_in_ready",  {15'd0, ir_c}, 16'd1);
    chk("midrst_result",    r_c,           16'h0000);
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("aborted_no_output", {15'd0, ov_c}, 16'd0);
    end

    // Next op after the abort: SBC 0x1000 - 0x0001 - C
    op_c = OP_SBC; a_c = 16'h1000; b_c = 16'h0001; f_c = 8'h01; iv_c = 1'b1;
    tick;
    iv_c = 1'b0;
    tick;
    tick;
    tick;
    tick;
    chk("sbc_out_valid", {15'd0, ov_c}, 16'd1);
    chk("sbc_result",    r_c,           16'h0FFE);
    chk("sbc_fout",      {8'd0, fo_c},  16'h0012);
    or_c = 1'b1;
    tick;
    or_c = 1'b0;
    chk("sbc_back_idle", {15'd0, ir_c}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
